// File: rtl/router_pkg.sv
// Shared types and constants for the router write-side packet controller.
package router_pkg;
   localparam int DATA_W = 8;
   localparam int N_DEST = 3;
   localparam int CNT_W  = 6;
   localparam logic [1:0] ADDR_INVALID = 2'd3;

   typedef enum logic [2:0] {
      DECODE_ADDRESS,
      WAIT_TILL_EMPTY,
      LOAD_FIRST_DATA,
      LOAD_DATA,
      FIFO_FULL_STATE,
      LOAD_AFTER_FULL,
      CHECK_PARITY
   } state_e;

   // Per-destination flag select; the invalid address reads as 0.
   function automatic logic sel_dest(input logic [N_DEST-1:0] v, input logic [1:0] a);
      logic [3:0] ext;
      ext = '0;
      ext[N_DEST-1:0] = v;
      return ext[a];
   endfunction
endpackage

// File: rtl/router_pkt_ctrl_fsm.sv
// State register and next-state logic of the router packet controller.
module router_pkt_ctrl_fsm
   import router_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        pkt_valid,
   input  logic [1:0]  hdr_addr,
   input  logic [1:0]  cur_addr,
   input  logic [2:0]  fifo_full,
   input  logic [2:0]  fifo_empty,
   input  logic [2:0]  soft_reset,
   input  logic        hold_is_par,
   output logic [2:0]  state,
   output logic        hdr_take
);
   state_e state_q, state_d;
   logic   drop_q, drop_d;
   logic   full_a, empty_a, sr_a;

   always_comb begin
      state_d  = state_q;
      drop_d   = drop_q;
      hdr_take = 1'b0;
      full_a   = sel_dest(fifo_full, cur_addr);
      empty_a  = sel_dest(fifo_empty, cur_addr);
      sr_a     = sel_dest(soft_reset, cur_addr);
      // drop_q swallows the rest of a packet sent to the invalid address
      if (!pkt_valid) drop_d = 1'b0;
      if (state_q != DECODE_ADDRESS && sr_a) begin
         state_d = DECODE_ADDRESS;
      end else begin
         case (state_q)
            DECODE_ADDRESS:
               if (pkt_valid && !drop_q) begin
                  if (hdr_addr == ADDR_INVALID) begin
                     drop_d = 1'b1;
                  end else begin
                     hdr_take = 1'b1;
                     state_d  = sel_dest(fifo_empty, hdr_addr) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                  end
               end
            WAIT_TILL_EMPTY: if (empty_a) state_d = LOAD_FIRST_DATA;
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA:
               if (full_a)          state_d = FIFO_FULL_STATE;
               else if (!pkt_valid) state_d = CHECK_PARITY;
            FIFO_FULL_STATE: if (!full_a) state_d = LOAD_AFTER_FULL;
            LOAD_AFTER_FULL: state_d = hold_is_par ? CHECK_PARITY : LOAD_DATA;
            CHECK_PARITY:    state_d = DECODE_ADDRESS;
            default:         state_d = DECODE_ADDRESS;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= DECODE_ADDRESS;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         drop_q  <= drop_d;
      end
   end

   assign state = state_q;
endmodule

// File: rtl/router_pkt_ctrl.sv
// Write-side packet controller of the 1x3 router: header decode, FIFO write
// steering, full-stall hold buffer, parity and length checking.
module router_pkt_ctrl
   import router_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        pkt_valid,
   input  logic [7:0]  data_in,
   input  logic [2:0]  fifo_full,
   input  logic [2:0]  fifo_empty,
   input  logic [2:0]  soft_reset,
   output logic [7:0]  dout,
   output logic [2:0]  write_enb,
   output logic        lfd_state,
   output logic        busy,
   output logic        parity_done,
   output logic        err,
   output logic        len_err
);
   logic [DATA_W-1:0] hdr_q, hdr_d, hold_q, hold_d, par_q, par_d, rx_par_q, rx_par_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              hold_par_q, hold_par_d, ovf_q, ovf_d;
   logic [2:0]        state_raw;
   state_e            state;
   logic              hdr_take, abort, full_a, wr, pay_wr;
   logic [DATA_W-1:0] pay_byte;
   logic [1:0]        addr;
   logic [CNT_W-1:0]  len;

   router_pkt_ctrl_fsm u_fsm (
      .clk         (clk),
      .reset       (reset),
      .pkt_valid   (pkt_valid),
      .hdr_addr    (data_in[1:0]),
      .cur_addr    (addr),
      .fifo_full   (fifo_full),
      .fifo_empty  (fifo_empty),
      .soft_reset  (soft_reset),
      .hold_is_par (hold_par_q),
      .state       (state_raw),
      .hdr_take    (hdr_take)
   );

   assign state  = state_e'(state_raw);
   assign addr   = hdr_q[1:0];
   assign len    = hdr_q[7:2];
   assign abort  = (state != DECODE_ADDRESS) && sel_dest(soft_reset, addr);
   assign full_a = sel_dest(fifo_full, addr);

   always_comb begin
      hdr_d       = hdr_q;
      hold_d      = hold_q;
      hold_par_d  = hold_par_q;
      par_d       = par_q;
      rx_par_d    = rx_par_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      dout        = '0;
      wr          = 1'b0;
      lfd_state   = 1'b0;
      busy        = 1'b0;
      parity_done = 1'b0;
      err         = 1'b0;
      len_err     = 1'b0;
      pay_wr      = 1'b0;
      pay_byte    = data_in;
      case (state)
         WAIT_TILL_EMPTY: busy = 1'b1;
         LOAD_FIRST_DATA: begin
            busy      = 1'b1;
            dout      = hdr_q;
            wr        = 1'b1;
            lfd_state = 1'b1;
         end
         LOAD_DATA: begin
            dout = data_in;
            if (!abort) begin
               if (!full_a) begin
                  wr = 1'b1;
                  if (pkt_valid) pay_wr   = 1'b1;
                  else           rx_par_d = data_in;
               end else begin
                  hold_d     = data_in;
                  hold_par_d = !pkt_valid;
               end
            end
         end
         FIFO_FULL_STATE: busy = 1'b1;
         LOAD_AFTER_FULL: begin
            busy = 1'b1;
            dout = hold_q;
            wr   = 1'b1;
            if (hold_par_q) begin
               rx_par_d = hold_q;
            end else begin
               pay_wr   = 1'b1;
               pay_byte = hold_q;
            end
         end
         CHECK_PARITY: begin
            busy        = 1'b1;
            parity_done = 1'b1;
            err         = (par_q != rx_par_q);
            len_err     = (cnt_q != len) || ovf_q;
         end
         default: ;
      endcase
      if (abort) begin
         wr          = 1'b0;
         lfd_state   = 1'b0;
         pay_wr      = 1'b0;
         parity_done = 1'b0;
         err         = 1'b0;
         len_err     = 1'b0;
      end
      if (pay_wr) begin
         par_d = par_q ^ pay_byte;
         // saturate; a 64th payload byte can never match the 6-bit length
         if (cnt_q == {CNT_W{1'b1}}) ovf_d = 1'b1;
         else                        cnt_d = cnt_q + 1'b1;
      end
      if (hdr_take) begin
         hdr_d = data_in;
         par_d = data_in;
         cnt_d = '0;
         ovf_d = 1'b0;
      end
      write_enb = wr ? (3'b001 << addr) : 3'b000;
      if (reset) begin
         dout        = '0;
         write_enb   = '0;
         lfd_state   = 1'b0;
         busy        = 1'b0;
         parity_done = 1'b0;
         err         = 1'b0;
         len_err     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hdr_q      <= '0;
         hold_q     <= '0;
         hold_par_q <= 1'b0;
         par_q      <= '0;
         rx_par_q   <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
      end else begin
         hdr_q      <= hdr_d;
         hold_q     <= hold_d;
         hold_par_q <= hold_par_d;
         par_q      <= par_d;
         rx_par_q   <= rx_par_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
      end
   end
endmodule

// File: tb/tb_router_pkt_ctrl.sv
// Self-checking bench for router_pkt_ctrl: a busy-respecting packet source,
// a per-packet expected write stream and a per-cycle output checker.
module tb_router_pkt_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       pkt_valid = 1'b0;
   logic [7:0] data_in = '0;
   logic [2:0] fifo_full = '0;
   logic [2:0] fifo_empty = 3'b111;
   logic [2:0] soft_reset = '0;
   logic [7:0] dout;
   logic [2:0] write_enb;
   logic       lfd_state, busy, parity_done, err, len_err;

   router_pkt_ctrl dut (
      .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
      .dout(dout), .write_enb(write_enb), .lfd_state(lfd_state), .busy(busy),
      .parity_done(parity_done), .err(err), .len_err(len_err)
   );

   always #5 clk = ~clk;

   typedef struct { logic [7:0] b; bit lfd; } ent_t;
   ent_t exp_q[$];
   int   exp_dest = 0;
   bit   exp_err = 0, exp_len = 0;
   int   n_cmp = 0, n_bad = 0;
   int   pd_cnt = 0, wr_cnt = 0, busy_cnt = 0, full_wr = 0;
   logic last_err, last_len;
   int   stall_cnt = 0, stall_bit = 0, empty_cnt = 0, empty_bit = 0;
   bit   rnd = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle checker: every write must be the next byte the model expects.
   always @(negedge clk) begin
      ent_t e;
      if (reset) begin
         chk("reset_outputs", {21'd0, dout, write_enb, lfd_state, busy, parity_done, err, len_err}, 32'd0);
      end else begin
         if (busy) busy_cnt++;
         if (write_enb != 3'b000) begin
            wr_cnt++;
            if (((write_enb & fifo_full) != 3'b000) && !lfd_state) full_wr++;
            chk("write_dest", {29'd0, write_enb}, 32'd1 << exp_dest);
            if (exp_q.size() == 0) begin
               chk("unexpected_write", {29'd0, write_enb}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("dout", {24'd0, dout}, {24'd0, e.b});
               chk("lfd_on_write", {31'd0, lfd_state}, {31'd0, e.lfd});
            end
         end else begin
            chk("lfd_idle", {31'd0, lfd_state}, 32'd0);
         end
         if (parity_done) begin
            pd_cnt++;
            last_err = err;
            last_len = len_err;
            chk("err", {31'd0, err}, {31'd0, exp_err});
            chk("len_err", {31'd0, len_err}, {31'd0, exp_len});
         end else begin
            chk("pulse_idle", {30'd0, err, len_err}, 32'd0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (stall_cnt > 0) begin
         stall_cnt--;
         if (stall_cnt == 0) fifo_full[stall_bit] = 1'b0;
      end
      if (empty_cnt > 0) begin
         empty_cnt--;
         if (empty_cnt == 0) fifo_empty[empty_bit] = 1'b1;
      end
      if (rnd) begin
         for (int i = 0; i < 3; i++) begin
            fifo_full[i]  = ($urandom_range(0, 4) == 0);
            fifo_empty[i] = ($urandom_range(0, 3) != 0);
         end
      end
   endtask

   // Present one byte and hold it until a cycle with busy low has passed.
   task automatic send_byte(input logic [7:0] b, input bit v);
      bit acc;
      int n;
      data_in = b;
      pkt_valid = v;
      acc = 0;
      n = 0;
      while (!acc && n < 500) begin
         @(negedge clk);
         acc = !busy;
         tick();
         n++;
      end
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   // abort_kind: 0 none, 1 soft_reset, 2 reset; abort lands on payload byte abort_at.
   task automatic send_pkt(input logic [7:0] hdr, input int npay, input bit bad_par,
                           input int stall_at, input int stall_len, input int empty_dly,
                           input int abort_at, input int abort_kind);
      logic [7:0] pl[$];
      logic [7:0] par;
      int dest, pd0, n;
      ent_t e;
      dest = int'(hdr[1:0]);
      par = hdr;
      pl.delete();
      for (int i = 0; i < npay; i++) begin
         pl.push_back(8'($urandom));
         par = par ^ pl[i];
      end
      exp_dest = dest;
      exp_err  = bad_par;
      exp_len  = (npay != int'(hdr[7:2]));
      if (dest != 3) begin
         e.b = hdr; e.lfd = 1; exp_q.push_back(e);
         for (int i = 0; i < npay; i++) begin
            if (abort_at == 0 || i < abort_at - 1) begin
               e.b = pl[i]; e.lfd = 0; exp_q.push_back(e);
            end
         end
         if (abort_at == 0) begin
            e.b = par ^ {7'd0, bad_par}; e.lfd = 0; exp_q.push_back(e);
         end
      end
      pd0 = pd_cnt; wr_cnt = 0; busy_cnt = 0; full_wr = 0;
      last_err = 1'bx; last_len = 1'bx;
      if (empty_dly > 0) begin
         fifo_empty[dest] = 1'b0; empty_bit = dest; empty_cnt = empty_dly;
      end
      send_byte(hdr, 1);
      for (int i = 1; i <= npay; i++) begin
         if (i == abort_at) begin
            data_in = pl[i-1];
            if (abort_kind == 1) begin
               soft_reset[dest] = 1'b1;
               tick();
               soft_reset = '0;
               pkt_valid = 1'b0;
            end else begin
               reset = 1'b1;
               tick();
               pkt_valid = 1'b0;
               tick();
               reset = 1'b0;
            end
            repeat (5) tick();
            chk("abort_no_pending", exp_q.size(), 32'd0);
            chk("abort_no_parity_done", pd_cnt - pd0, 32'd0);
            chk("abort_idle_busy", {31'd0, busy}, 32'd0);
            exp_q.delete();
            return;
         end
         if (i == stall_at) begin
            fifo_full[dest] = 1'b1; stall_bit = dest; stall_cnt = stall_len;
         end
         send_byte(pl[i-1], 1);
      end
      send_byte(par ^ {7'd0, bad_par}, 0);
      data_in = 8'h00;
      if (dest != 3) begin
         n = 0;
         while (pd_cnt == pd0 && n < 400) begin tick(); n++; end
         chk("parity_done_once", pd_cnt - pd0, 32'd1);
         chk("all_bytes_written", exp_q.size(), 32'd0);
      end else begin
         repeat (4) tick();
         chk("invalid_no_parity_done", pd_cnt - pd0, 32'd0);
      end
      exp_q.delete();
      tick();
   endtask

   initial begin
      int len, npay, dest;
      // reset with live-looking input so gating is meaningful
      reset = 1'b1; pkt_valid = 1'b1; data_in = 8'h38;
      repeat (3) tick();
      reset = 1'b0; pkt_valid = 1'b0; data_in = 8'h00;
      @(negedge clk);
      chk("post_reset_outputs", {21'd0, dout, write_enb, lfd_state, busy, parity_done, err, len_err}, 32'd0);
      tick();

      // len 14, addr 0: header + 14 payload + parity, busy only in LFD and CHECK
      send_pkt(8'h38, 14, 0, 0, 0, 0, 0, 0);
      chk("t1_writes", wr_cnt, 32'd16);
      chk("t1_busy_cycles", busy_cnt, 32'd2);
      chk("t1_err", {31'd0, last_err}, 32'd0);
      chk("t1_len_err", {31'd0, last_len}, 32'd0);

      send_pkt(8'h38, 14, 1, 0, 0, 0, 0, 0);
      chk("t2_writes", wr_cnt, 32'd16);
      chk("t2_err", {31'd0, last_err}, 32'd1);

      // 5-cycle full at payload byte 3: 1 hold cycle, 5 busy stall/resume, 1 busy rewrite
      send_pkt(8'h39, 14, 0, 3, 5, 0, 0, 0);
      chk("t3_writes", wr_cnt, 32'd16);
      chk("t3_busy_cycles", busy_cnt, 32'd8);
      chk("t3_write_while_full", full_wr, 32'd0);

      // FIFO2 not empty for 4 cycles: 4 WAIT cycles + LFD + CHECK busy
      send_pkt(8'h0A, 3, 0, 0, 0, 4, 0, 0);
      chk("t4_writes", wr_cnt, 32'd5);
      chk("t4_busy_cycles", busy_cnt, 32'd6);
      chk("t4_len_err", {31'd0, last_len}, 32'd1);

      send_pkt(8'h07, 5, 0, 0, 0, 0, 0, 0);
      chk("t5_writes", wr_cnt, 32'd0);
      chk("t5_busy_cycles", busy_cnt, 32'd0);

      send_pkt(8'h38, 14, 0, 0, 0, 0, 5, 1);
      chk("t6_writes", wr_cnt, 32'd5);
      send_pkt(8'h39, 14, 0, 0, 0, 0, 4, 2);
      chk("t7_writes", wr_cnt, 32'd4);

      // length 63 boundary: 63 bytes match, 64 overflow the counter
      send_pkt(8'hFD, 63, 0, 0, 0, 0, 0, 0);
      chk("t8_len_ok", {31'd0, last_len}, 32'd0);
      send_pkt(8'hFD, 64, 0, 0, 0, 0, 0, 0);
      chk("t8_len_ovf", {31'd0, last_len}, 32'd1);
      chk("t8_writes", wr_cnt, 32'd66);

      rnd = 1;
      for (int p = 0; p < 30; p++) begin
         dest = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
         len  = int'($urandom_range(0, 20));
         npay = len;
         case ($urandom_range(0, 5))
            0: npay = len + 1;
            1: npay = (len > 0) ? len - 1 : 1;
            default: ;
         endcase
         send_pkt({len[5:0], dest[1:0]}, npay, ($urandom_range(0, 3) == 0), 0, 0, 0, 0, 0);
         chk("rnd_writes", wr_cnt, (dest == 3) ? 32'd0 : 32'(npay + 2));
      end
      rnd = 0;
      fifo_full = '0; fifo_empty = 3'b111;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/router_pkt_ctrl.md
Name: router_pkt_ctrl

Overview:
Write-side packet controller of the 1x3 router; sits directly upstream of the three per-destination router_fifo instances. It accepts byte-serial packets from the source (header, payload, parity), decodes the destination from the header, and drives data, write enable and the lfd_state first-byte marker into the selected FIFO. It stalls the source via busy on FIFO full or non-empty destination, and checks parity and length.

Parameters:
DATA_W, 8, byte width (packet format fixed to 8)
N_DEST, 3, destination FIFOs; address 2'd3 is invalid
CNT_W, 6, payload length counter width (max payload 63)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
pkt_valid  in  1  high from header byte through last payload byte; low on the parity byte
data_in  in  8  packet byte; source holds it stable while busy=1
fifo_full  in  3  full flags of FIFO 0..2
fifo_empty  in  3  empty flags of FIFO 0..2
soft_reset  in  3  per-FIFO timeout resets from the read side
dout  out  8  byte to FIFOs (shared bus)
write_enb  out  3  one-hot FIFO write strobe
lfd_state  out  1  high while the header byte is written
busy  out  1  source must hold data_in
parity_done  out  1  one-cycle pulse, packet closed
err  out  1  one-cycle pulse, parity mismatch
len_err  out  1  one-cycle pulse, payload count differs from header length

Behaviour:
- Header = {len[7:2], addr[1:0]}. Internal parity = XOR of header and all payload bytes.
- Reset: state DECODE_ADDRESS; hdr_reg, hold_reg, par_reg, cnt cleared. All outputs 0 and dout 8'h00 during and right after reset. Reset mid-packet aborts with no writes.
- Outputs are combinational from the state and current inputs. A write happens at the clk edge where write_enb is high.
- DECODE_ADDRESS: busy=0. On pkt_valid with addr!=3, capture hdr_reg and set par_reg=header. Go to LOAD_FIRST_DATA if fifo_empty[addr], else WAIT_TILL_EMPTY. On addr==3, drop the byte and stay; later bytes of that packet are ignored until pkt_valid falls.
- WAIT_TILL_EMPTY: busy=1. Go to LOAD_FIRST_DATA once fifo_empty[addr] is high.
- LOAD_FIRST_DATA: dout=hdr_reg, write_enb[addr]=1, lfd_state=1, busy=1. Then LOAD_DATA. The header write ignores fifo_full because the FIFO is empty.
- LOAD_DATA: busy=0, dout=data_in.
  - pkt_valid=1 and !fifo_full[addr]: write the byte, par_reg^=data_in, cnt++.
  - pkt_valid=1 and full: no write; hold_reg=data_in, hold_is_par=0; go to FIFO_FULL_STATE.
  - pkt_valid=0 (parity byte) and !full: write it, capture rx_parity; go to CHECK_PARITY.
  - pkt_valid=0 and full: hold it with hold_is_par=1; go to FIFO_FULL_STATE.
- FIFO_FULL_STATE: busy=1, no write. Go to LOAD_AFTER_FULL when !fifo_full[addr].
- LOAD_AFTER_FULL: busy=1, dout=hold_reg, write once. Payload bytes update par_reg and cnt here. Next state is CHECK_PARITY if hold_is_par, else LOAD_DATA.
- CHECK_PARITY: busy=1, parity_done=1, err=(par_reg!=rx_parity), len_err=(cnt!=len). Then DECODE_ADDRESS.
- soft_reset[addr] in any state other than DECODE_ADDRESS: abort to DECODE_ADDRESS next cycle with no write that cycle. Pulses are suppressed. Takes priority over all other transitions.
- Counter saturates at 63; overflow forces len_err.
- Header-to-first-payload latency: 2 cycles when the FIFO is empty (decode, then header write). The source must drop pkt_valid exactly on the parity byte.

Decomposition:
- Package router_pkg: state enum (DECODE_ADDRESS, WAIT_TILL_EMPTY, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, CHECK_PARITY), ADDR_INVALID=2'd3, DATA_W and N_DEST.
- One sub-module, router_pkt_ctrl_fsm: state register and next-state logic. The datapath registers and output muxing stay in the top.

Test Plan:
- Empty FIFO 0, header 8'h38 (len 14, addr 0), 14 random payload bytes, correct parity: 16 writes to FIFO0; lfd_state high only on the header write; parity_done pulses once; err=0, len_err=0; busy high only during LOAD_FIRST_DATA and CHECK_PARITY.
- Same packet with the parity byte XOR 8'h01: err pulses 1 cycle with parity_done; all 16 bytes still written.
- Addr 1, fifo_full[1] asserted for 5 cycles at payload byte 3: busy=1 throughout the stall, no write_enb, and the held byte is written exactly once afterwards. Data order is preserved and FIFO1 receives 16 bytes.
- Header 8'h0A (len 2, addr 2) with fifo_empty[2]=0 for 4 cycles: busy stays high in WAIT_TILL_EMPTY, then the header is written with lfd_state=1. Sending 3 payload bytes gives len_err=1.
- Header 8'h07 (addr 3): write_enb stays 3'b000 for the whole packet and the block returns to DECODE_ADDRESS.
- soft_reset[0] pulsed mid-payload, then reset asserted mid-packet: both abort to DECODE_ADDRESS, with no further writes and no parity_done.
